// File: rtl/vga_pixel_pkg.sv
// Shared definitions for the 8-bit scaled-pixel frame buffer format {type[1:0], data[5:0]}.
// The writer produces this format and the display-side mux decodes it.
package vga_pixel_pkg;

    localparam logic [1:0] TYPE_GRAY  = 2'b00;
    localparam logic [1:0] TYPE_DRAWN = 2'b11;

    localparam logic [5:0] COLOR_MAGENTA = 6'b111111;
    localparam logic [5:0] COLOR_YELLOW  = 6'b101010;
    localparam logic [5:0] COLOR_BLUE    = 6'b000000;

    typedef enum logic [1:0] {
        SEL_MAGENTA  = 2'b00,
        SEL_YELLOW   = 2'b01,
        SEL_BLUE     = 2'b10,
        SEL_BLUE_ALT = 2'b11
    } color_sel_e;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } fbw_state_e;

    // Map an overlay colour select onto its 6-bit drawn-colour code.
    function automatic logic [5:0] drawn_code(input color_sel_e sel);
        case (sel)
            SEL_MAGENTA: return COLOR_MAGENTA;
            SEL_YELLOW:  return COLOR_YELLOW;
            default:     return COLOR_BLUE;
        endcase
    endfunction

endpackage

// File: rtl/frame_buffer_writer_if.sv
// Pixel-stream input and BRAM write-port output of the frame buffer writer.
// master = camera/drawing side driving pixels; slave = the writer itself.
interface frame_buffer_writer_if #(
    parameter int ADDR_W = 16
);
    import vga_pixel_pkg::*;

    logic              frame_start_in;
    logic              pixel_valid_in;
    logic [10:0]       hcount_in;
    logic [9:0]        vcount_in;
    logic [15:0]       pixel_in;
    logic              draw_in;
    color_sel_e        color_sel_in;

    logic [ADDR_W-1:0] bram_addr_out;
    logic [7:0]        bram_data_out;
    logic              bram_we_out;
    logic              frame_done_out;
    logic              overflow_out;

    modport master (
        output frame_start_in, pixel_valid_in, hcount_in, vcount_in,
               pixel_in, draw_in, color_sel_in,
        input  bram_addr_out, bram_data_out, bram_we_out, frame_done_out, overflow_out
    );

    modport slave (
        input  frame_start_in, pixel_valid_in, hcount_in, vcount_in,
               pixel_in, draw_in, color_sel_in,
        output bram_addr_out, bram_data_out, bram_we_out, frame_done_out, overflow_out
    );

endinterface

// File: rtl/rgb565_to_gray6.sv
// RGB565 to 6-bit luma: registers the weighted sum 2*r6 + 5*g6 + b6, then divides by 8.
module rgb565_to_gray6 (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [15:0] pixel_in,
    output logic [5:0]  gray6_out
);

    logic [5:0] r6, g6, b6;
    logic [8:0] sum_d, sum_q;

    // Expand 5-bit channels to 6 bits by replicating the MSB and form the luma sum.
    always_comb begin
        r6    = {pixel_in[15:11], pixel_in[15]};
        g6    = pixel_in[10:5];
        b6    = {pixel_in[4:0], pixel_in[4]};
        // Maximum is 504, so 9 bits never overflow.
        sum_d = {2'b00, r6, 1'b0} + ({3'b000, g6} << 2) + {3'b000, g6} + {3'b000, b6};
    end

    // Pipeline register for the partial sum.
    always_ff @(posedge clk_in) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst_in) sum_q <= '0;
        else        sum_q <= sum_d;
    end

    assign gray6_out = sum_q[8:3];

endmodule

// File: rtl/frame_buffer_writer.sv
// Decimates the camera/overlay pixel stream and writes encoded pixels sequentially into BRAM.
// Two-stage pipeline: stage 1 holds address/controls/partial luma, stage 2 holds the final write.
module frame_buffer_writer
    import vga_pixel_pkg::*;
#(
    parameter int H_ACTIVE    = 1024,
    parameter int V_ACTIVE    = 768,
    parameter int SCALE_SHIFT = 2,
    parameter int ADDR_W      = 16
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    frame_buffer_writer_if.slave  bus
);

    localparam int                DEPTH     = (H_ACTIVE >> SCALE_SHIFT) * (V_ACTIVE >> SCALE_SHIFT);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [10:0]       H_MASK    = 11'((1 << SCALE_SHIFT) - 1);
    localparam logic [9:0]        V_MASK    = 10'((1 << SCALE_SHIFT) - 1);

    fbw_state_e        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              full_q, full_d;   // frame completed, no frame_start_in seen since
    logic              ovf_q, ovf_d;

    logic              s1_we_q, s1_we_d;
    logic              s1_done_q, s1_done_d;
    logic              s1_draw_q, s1_draw_d;
    color_sel_e        s1_sel_q, s1_sel_d;
    logic [ADDR_W-1:0] s1_addr_q, s1_addr_d;

    logic              s2_we_q, s2_we_d;
    logic              s2_done_q, s2_done_d;
    logic [ADDR_W-1:0] s2_addr_q, s2_addr_d;
    logic [7:0]        s2_data_q, s2_data_d;

    logic              keep;
    logic [ADDR_W-1:0] wr_addr;
    logic [5:0]        gray6;

    rgb565_to_gray6 u_gray (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .pixel_in  (bus.pixel_in),
        .gray6_out (gray6)
    );

    // Keep rule: valid, inside the active area, and on the decimation grid in both axes.
    always_comb begin
        keep = bus.pixel_valid_in
            && (int'(bus.hcount_in) < H_ACTIVE)
            && (int'(bus.vcount_in) < V_ACTIVE)
            && ((bus.hcount_in & H_MASK) == '0)
            && ((bus.vcount_in & V_MASK) == '0);
    end

    // Frame FSM, address counter, overflow flag and stage-1 capture.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        full_d    = full_q;
        ovf_d     = ovf_q;
        s1_we_d   = 1'b0;
        s1_done_d = 1'b0;
        s1_draw_d = bus.draw_in;
        s1_sel_d  = bus.color_sel_in;
        // A kept pixel coincident with frame_start_in belongs to the new frame at address 0.
        wr_addr   = bus.frame_start_in ? '0 : cnt_q;
        s1_addr_d = wr_addr;

        if (bus.frame_start_in) begin
            state_d = ST_ACTIVE;
            cnt_d   = '0;
            full_d  = 1'b0;
            ovf_d   = 1'b0;
        end

        if (keep) begin
            if (bus.frame_start_in || state_q == ST_ACTIVE) begin
                s1_we_d = 1'b1;
                cnt_d   = wr_addr + 1'b1;
                if (wr_addr == LAST_ADDR) begin
                    s1_done_d = 1'b1;
                    state_d   = ST_IDLE;
                    cnt_d     = '0;
                    full_d    = 1'b1;
                end
            end else if (full_q) begin
                ovf_d = 1'b1;
            end
        end
    end

    // Stage 2: final encoding of the pixel carried with its stage-1 address.
    always_comb begin
        s2_we_d   = s1_we_q;
        s2_done_d = s1_done_q;
        s2_addr_d = s1_addr_q;
        s2_data_d = s1_draw_q ? {TYPE_DRAWN, drawn_code(s1_sel_q)} : {TYPE_GRAY, gray6};
    end

    // State and pipeline registers; reset squashes any write in flight.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            full_q    <= 1'b0;
            ovf_q     <= 1'b0;
            s1_we_q   <= 1'b0;
            s1_done_q <= 1'b0;
            s1_draw_q <= 1'b0;
            s1_sel_q  <= SEL_MAGENTA;
            s1_addr_q <= '0;
            s2_we_q   <= 1'b0;
            s2_done_q <= 1'b0;
            s2_addr_q <= '0;
            s2_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            full_q    <= full_d;
            ovf_q     <= ovf_d;
            s1_we_q   <= s1_we_d;
            s1_done_q <= s1_done_d;
            s1_draw_q <= s1_draw_d;
            s1_sel_q  <= s1_sel_d;
            s1_addr_q <= s1_addr_d;
            s2_we_q   <= s2_we_d;
            s2_done_q <= s2_done_d;
            s2_addr_q <= s2_addr_d;
            s2_data_q <= s2_data_d;
        end
    end

    assign bus.bram_addr_out  = s2_addr_q;
    assign bus.bram_data_out  = s2_data_q;
    assign bus.bram_we_out    = s2_we_q;
    assign bus.frame_done_out = s2_done_q;
    assign bus.overflow_out   = ovf_q;

endmodule

// File: tb/tb_frame_buffer_writer.sv
// Self-checking bench for frame_buffer_writer on a reduced 64x48 raster (DEPTH = 16*12 = 192).
module tb_frame_buffer_writer;
    import vga_pixel_pkg::*;

    localparam int H     = 64;
    localparam int V     = 48;
    localparam int SS    = 2;
    localparam int AW    = 8;
    localparam int SC    = 1 << SS;
    localparam int DEPTH = (H / SC) * (V / SC);

    typedef struct {
        bit we;
        int addr;
        int data;
        bit done;
    } wr_t;

    logic clk_in = 1'b0;
    logic rst_in = 1'b1;

    frame_buffer_writer_if #(.ADDR_W(AW)) bus ();

    frame_buffer_writer #(
        .H_ACTIVE    (H),
        .V_ACTIVE    (V),
        .SCALE_SHIFT (SS),
        .ADDR_W      (AW)
    ) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    int  n_tests = 0;
    int  n_fail  = 0;

    // Reference model: frame open/closed, next address, frame-completed and overflow flags.
    bit  m_active, m_full, m_ovf;
    int  m_addr;
    wr_t pipe[$];

    int  done_cnt, wr_cnt, last_done_addr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected 8-bit encoding straight from the format rules.
    function automatic int enc(input logic [15:0] p, input bit draw, input int sel);
        int r, g, b;
        if (draw) begin
            case (sel)
                0:       return 8'hFF;
                1:       return 8'hEA;
                default: return 8'hC0;
            endcase
        end
        r = int'(p[15:11]);
        g = int'(p[10:5]);
        b = int'(p[4:0]);
        r = r * 2 + r / 16;
        b = b * 2 + b / 16;
        return (2 * r + 5 * g + b) / 8;
    endfunction

    task automatic drive_idle();
        bus.frame_start_in = 1'b0;
        bus.pixel_valid_in = 1'b0;
        bus.hcount_in      = '0;
        bus.vcount_in      = '0;
        bus.pixel_in       = '0;
        bus.draw_in        = 1'b0;
        bus.color_sel_in   = SEL_MAGENTA;
    endtask

    task automatic do_reset();
        drive_idle();
        rst_in = 1'b1;
        @(posedge clk_in); #1;
        check("rst_we",   32'(bus.bram_we_out),    0);
        check("rst_addr", 32'(bus.bram_addr_out),  0);
        check("rst_data", 32'(bus.bram_data_out),  0);
        check("rst_done", 32'(bus.frame_done_out), 0);
        check("rst_ovf",  32'(bus.overflow_out),   0);
        rst_in   = 1'b0;
        m_active = 1'b0;
        m_full   = 1'b0;
        m_ovf    = 1'b0;
        m_addr   = 0;
        pipe.delete();
        pipe.push_back('{we: 1'b0, addr: 0, data: 0, done: 1'b0});
    endtask

    // One clock of stimulus; outputs checked against the model's result from the previous step,
    // which together with stage-1 capture gives the two-cycle write latency.
    task automatic step(input bit fs, input bit vld, input int h, input int v,
                        input logic [15:0] pix, input bit draw, input int sel);
        wr_t e;
        bit  keep;
        e = '{we: 1'b0, addr: 0, data: 0, done: 1'b0};
        bus.frame_start_in = fs;
        bus.pixel_valid_in = vld;
        bus.hcount_in      = 11'(h);
        bus.vcount_in      = 10'(v);
        bus.pixel_in       = pix;
        bus.draw_in        = draw;
        bus.color_sel_in   = color_sel_e'(sel[1:0]);

        keep = vld && (h < H) && (v < V) && (h % SC == 0) && (v % SC == 0);
        if (fs) begin
            m_active = 1'b1;
            m_addr   = 0;
            m_full   = 1'b0;
            m_ovf    = 1'b0;
        end
        if (keep && m_active) begin
            e = '{we: 1'b1, addr: m_addr, data: enc(pix, draw, sel), done: (m_addr == DEPTH - 1)};
            if (m_addr == DEPTH - 1) begin
                m_active = 1'b0;
                m_full   = 1'b1;
                m_addr   = 0;
            end else begin
                m_addr++;
            end
        end else if (keep && m_full) begin
            m_ovf = 1'b1;
        end
        pipe.push_back(e);

        @(posedge clk_in); #1;
        e = pipe.pop_front();
        check("we", 32'(bus.bram_we_out), 32'(e.we));
        if (e.we) begin
            check("addr", 32'(bus.bram_addr_out),  32'(e.addr));
            check("data", 32'(bus.bram_data_out),  32'(e.data));
            check("done", 32'(bus.frame_done_out), 32'(e.done));
        end else begin
            check("done_idle", 32'(bus.frame_done_out), 0);
        end
        check("ovf", 32'(bus.overflow_out), 32'(m_ovf));
        if (bus.bram_we_out) wr_cnt++;
        if (bus.bram_we_out && bus.frame_done_out) begin
            done_cnt++;
            last_done_addr = int'(bus.bram_addr_out);
        end
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 0, 16'h0000, 1'b0, 0);
    endtask

    initial begin
        int  h, v;
        bit  short_done;
        drive_idle();
        do_reset();

        // Kept pixels after reset but before any frame_start_in: no writes, no overflow.
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, i * SC, 0, 16'hFFFF, 1'b0, 0);
        idle_steps(2);

        // frame_start_in coincident with a pure-red kept pixel: address 0, data 8'h0F.
        step(1'b1, 1'b1, 0, 0, 16'hF800, 1'b0, 0);
        // Drawn colours for each select value.
        for (int s = 0; s < 4; s++) step(1'b0, 1'b1, (s + 1) * SC, 0, 16'h1234, 1'b1, s);
        idle_steps(3);

        // Random stimulus with a short frame restarted at address 100.
        step(1'b1, 1'b0, 0, 0, 16'h0000, 1'b0, 0);
        short_done = 1'b0;
        for (int i = 0; i < 600; i++) begin
            h = $urandom_range(0, H + 7);
            v = $urandom_range(0, V + 3);
            if ($urandom_range(0, 1) == 1) begin
                h = h & ~(SC - 1);
                v = v & ~(SC - 1);
            end
            step(1'b0, $urandom_range(0, 3) != 0, h, v, 16'($urandom),
                 1'($urandom_range(0, 1)), $urandom_range(0, 3));
            if (m_addr == 100 && !short_done) begin
                done_cnt   = 0;
                step(1'b1, 1'b0, 0, 0, 16'h0000, 1'b0, 0);
                idle_steps(2);
                check("short_no_done", 32'(done_cnt), 0);
                short_done = 1'b1;
            end
        end
        idle_steps(2);

        // Full white raster: DEPTH writes of 8'h3F, exactly one frame_done_out at DEPTH-1.
        step(1'b1, 1'b0, 0, 0, 16'h0000, 1'b0, 0);
        done_cnt = 0;
        wr_cnt   = 0;
        for (int y = 0; y < V; y++)
            for (int x = 0; x < H; x++)
                step(1'b0, 1'b1, x, y, 16'hFFFF, 1'b0, 0);
        idle_steps(2);
        check("raster_writes",    32'(wr_cnt),         32'(DEPTH));
        check("raster_done_cnt",  32'(done_cnt),       1);
        check("raster_done_addr", 32'(last_done_addr), 32'(DEPTH - 1));

        // Kept pixels after the frame is full: dropped, overflow set and held, cleared by frame_start_in.
        wr_cnt = 0;
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, i * SC, SC, 16'hABCD, 1'b0, 0);
        idle_steps(4);
        check("ovf_no_writes", 32'(wr_cnt), 0);
        check("ovf_held",      32'(bus.overflow_out), 1);
        step(1'b1, 1'b0, 0, 0, 16'h0000, 1'b0, 0);
        check("ovf_cleared", 32'(bus.overflow_out), 0);

        // Random-content raster so grayscale encoding sees varied pixels.
        for (int y = 0; y < V; y += SC)
            for (int x = 0; x < H; x += SC)
                step(1'b0, 1'b1, x, y, 16'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 3));
        idle_steps(2);

        // Reset with writes in both pipeline stages: squashed, pixels ignored until frame_start_in.
        step(1'b1, 1'b1, 0, 0, 16'h07E0, 1'b0, 0);
        step(1'b0, 1'b1, SC, 0, 16'h001F, 1'b0, 0);
        step(1'b0, 1'b1, 2 * SC, 0, 16'hFFFF, 1'b1, 1);
        do_reset();
        wr_cnt = 0;
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, i * SC, 0, 16'hFFFF, 1'b0, 0);
        idle_steps(2);
        check("post_rst_no_writes", 32'(wr_cnt), 0);
        step(1'b1, 1'b1, 0, 0, 16'h8410, 1'b0, 0);
        step(1'b0, 1'b1, SC, 0, 16'hFFFF, 1'b1, 2);
        idle_steps(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
